// File: rtl/coffee_brew_fsm.sv
// Coffee machine brew sequencer: IDLE -> HEAT -> GRIND -> [PREINF] -> BREW -> DONE -> IDLE,
// with a water-fault ERR state, abort handling and a completed-cup counter.
// Optional pre-infusion phase is enabled by defining COFFEE_PREINFUSE_EN.
// All outputs are registered and decoded from the state alone (Moore).
module coffee_brew_fsm #(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned HEAT_CYC   = 16,
  parameter int unsigned GRIND_CYC  = 8,
  parameter int unsigned BREW_S_CYC = 20,
  parameter int unsigned BREW_L_CYC = 40,
  parameter int unsigned DONE_CYC   = 4,
`ifdef COFFEE_PREINFUSE_EN
  parameter int unsigned PREINF_CYC = 6,
`endif
  parameter int unsigned CUP_W      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             size,
  input  logic             water_ok,
  input  logic             abort,
  output logic [2:0]       state_out,
  output logic             heater,
  output logic             grinder,
  output logic             pump,
  output logic             ready,
  output logic             done,
  output logic             err,
  output logic [CUP_W-1:0] cup_cnt
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StHeat   = 3'd1,
    StGrind  = 3'd2,
    StPreinf = 3'd3,
    StBrew   = 3'd4,
    StDone   = 3'd5,
    StErr    = 3'd6,
    StBad    = 3'd7
  } state_e;

  // Timer load values are N-1 so each timed state lasts exactly N cycles.
  localparam logic [CNT_W-1:0] HeatLd  = CNT_W'(HEAT_CYC - 1);
  localparam logic [CNT_W-1:0] GrindLd = CNT_W'(GRIND_CYC - 1);
  localparam logic [CNT_W-1:0] BrewSLd = CNT_W'(BREW_S_CYC - 1);
  localparam logic [CNT_W-1:0] BrewLLd = CNT_W'(BREW_L_CYC - 1);
  localparam logic [CNT_W-1:0] DoneLd  = CNT_W'(DONE_CYC - 1);
`ifdef COFFEE_PREINFUSE_EN
  localparam logic [CNT_W-1:0] PreLd   = CNT_W'(PREINF_CYC - 1);
`endif
  localparam logic [CNT_W-1:0] TmrOne  = CNT_W'(1);
  localparam logic [CUP_W-1:0] CupOne  = CUP_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             size_q, size_d;
  logic [CUP_W-1:0] cup_q, cup_d;
  logic             heater_q, grinder_q, pump_q, ready_q, done_q, err_q;

  // Next-state, timer, size latch and cup counter logic.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    size_d  = size_q;
    cup_d   = cup_q;
    case (state_q)
      StIdle: begin
        timer_d = '0;
        if (start) begin
          if (water_ok) begin
            state_d = StHeat;
            timer_d = HeatLd;
            size_d  = size;
          end else begin
            state_d = StErr;
          end
        end
      end
`ifdef COFFEE_PREINFUSE_EN
      StHeat, StGrind, StPreinf, StBrew: begin
`else
      StHeat, StGrind, StBrew: begin
`endif
        if (abort) begin
          state_d = StIdle;
          timer_d = '0;
        end else if (!water_ok) begin
          state_d = StErr;
          timer_d = '0;
        end else if (timer_q != '0) begin
          timer_d = timer_q - TmrOne;
        end else begin
          case (state_q)
            StHeat: begin
              state_d = StGrind;
              timer_d = GrindLd;
            end
`ifdef COFFEE_PREINFUSE_EN
            StGrind: begin
              state_d = StPreinf;
              timer_d = PreLd;
            end
            StPreinf: begin
              state_d = StBrew;
              timer_d = size_q ? BrewLLd : BrewSLd;
            end
`else
            StGrind: begin
              state_d = StBrew;
              timer_d = size_q ? BrewLLd : BrewSLd;
            end
`endif
            default: begin
              state_d = StDone;
              timer_d = DoneLd;
            end
          endcase
        end
      end
      StDone: begin
        // DONE deliberately ignores abort and water_ok.
        if (timer_q != '0) begin
          timer_d = timer_q - TmrOne;
        end else begin
          state_d = StIdle;
          cup_d   = cup_q + CupOne;
        end
      end
      StErr: begin
        timer_d = '0;
        if (abort) state_d = StIdle;
      end
      default: begin
        // Illegal codes (7, and 3 when pre-infusion is disabled) recover to IDLE.
        state_d = StIdle;
        timer_d = '0;
      end
    endcase
  end

  // State, datapath and registered Moore outputs decoded from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      size_q    <= 1'b0;
      cup_q     <= '0;
      heater_q  <= 1'b0;
      grinder_q <= 1'b0;
      pump_q    <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      size_q    <= size_d;
      cup_q     <= cup_d;
      heater_q  <= (state_d == StHeat) || (state_d == StPreinf) || (state_d == StBrew);
      grinder_q <= (state_d == StGrind);
      pump_q    <= (state_d == StPreinf) || (state_d == StBrew);
      ready_q   <= (state_d == StIdle);
      done_q    <= (state_d == StDone);
      err_q     <= (state_d == StErr);
    end
  end

  assign state_out = state_q;
  assign heater    = heater_q;
  assign grinder   = grinder_q;
  assign pump      = pump_q;
  assign ready     = ready_q;
  assign done      = done_q;
  assign err       = err_q;
  assign cup_cnt   = cup_q;

endmodule

// File: tb/tb_coffee_brew_fsm.sv
// Bench for coffee_brew_fsm: a schedule-based reference model (a queue of expected state codes
// per brew) checked every cycle, plus directed scenarios with literal expectations.
module tb_coffee_brew_fsm;

  localparam int CupMod = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       size = 1'b0;
  logic       water_ok = 1'b1;
  logic       abort = 1'b0;
  logic [2:0] state_out;
  logic       heater, grinder, pump, ready, done, err;
  logic [3:0] cup_cnt;

  int checks = 0;
  int errors = 0;

  coffee_brew_fsm dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .size     (size),
    .water_ok (water_ok),
    .abort    (abort),
    .state_out(state_out),
    .heater   (heater),
    .grinder  (grinder),
    .pump     (pump),
    .ready    (ready),
    .done     (done),
    .err      (err),
    .cup_cnt  (cup_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: on acceptance the whole brew is laid out as a list of per-cycle codes.
  int m_state = 0;
  int m_cups = 0;
  int sched[$];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_state = 0;
      m_cups  = 0;
      sched.delete();
    end else if (m_state == 0) begin
      if (start && water_ok) begin
        sched.delete();
        repeat (16) sched.push_back(1);
        repeat (8) sched.push_back(2);
`ifdef COFFEE_PREINFUSE_EN
        repeat (6) sched.push_back(3);
`endif
        repeat (size ? 40 : 20) sched.push_back(4);
        repeat (4) sched.push_back(5);
        sched.push_back(0);
        m_state = sched.pop_front();
      end else if (start) begin
        m_state = 6;
      end
    end else if (m_state == 6) begin
      if (abort) m_state = 0;
    end else if (m_state == 5) begin
      m_state = sched.pop_front();
      if (m_state == 0) m_cups = (m_cups + 1) % CupMod;
    end else begin
      if (abort) begin
        m_state = 0;
        sched.delete();
      end else if (!water_ok) begin
        m_state = 6;
        sched.delete();
      end else begin
        m_state = sched.pop_front();
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (!reset) begin
      check("state_out", int'(state_out), m_state);
      check("heater", int'(heater), int'(m_state == 1 || m_state == 3 || m_state == 4));
      check("grinder", int'(grinder), int'(m_state == 2));
      check("pump", int'(pump), int'(m_state == 3 || m_state == 4));
      check("ready", int'(ready), int'(m_state == 0));
      check("done", int'(done), int'(m_state == 5));
      check("err", int'(err), int'(m_state == 6));
      check("cup_cnt", int'(cup_cnt), m_cups);
    end
  end

  task automatic brew(input logic sz, input bit tog, output int total, output int n_pump,
                      output int n_heat, output int n_pre);
    total = 0;
    n_pump = 0;
    n_heat = 0;
    n_pre = 0;
    @(negedge clk);
    start = 1'b1;
    size = sz;
    water_ok = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!ready && total < 500) begin
      total++;
      if (pump) n_pump++;
      if (heater) n_heat++;
      if (state_out == 3'd3) n_pre++;
      if (tog && state_out == 3'd1) size = ~size;
      @(negedge clk);
    end
  endtask

  task automatic wait_state(input int code);
    int n = 0;
    while (int'(state_out) != code && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("wait_state", int'(state_out), code);
  endtask

`ifdef COFFEE_PREINFUSE_EN
  localparam int PreN = 6;
`else
  localparam int PreN = 0;
`endif

  initial begin
    int total, np, nh, npre;

    // Reset values while reset is held.
    @(negedge clk);
    check("rst_state", int'(state_out), 0);
    check("rst_ready", int'(ready), 1);
    check("rst_cup", int'(cup_cnt), 0);
    check("rst_outs", int'({heater, grinder, pump, done, err}), 0);
    reset = 1'b0;

    // Small brew.
    brew(1'b0, 1'b0, total, np, nh, npre);
    check("small_total", total, 48 + PreN);
    check("small_pump", np, 20 + PreN);
    check("small_heater", nh, 36 + PreN);
    check("small_preinf", npre, PreN);
    check("small_cup", int'(cup_cnt), 1);

    // Large brew with size toggled during HEAT.
    brew(1'b1, 1'b1, total, np, nh, npre);
    check("large_total", total, 68 + PreN);
    check("large_pump", np, 40 + PreN);
    check("large_cup", int'(cup_cnt), 2);

    // Abort on BREW cycle 10, then restart immediately.
    @(negedge clk);
    start = 1'b1;
    size = 1'b0;
    @(negedge clk);
    start = 1'b0;
    wait_state(4);
    repeat (9) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_state", int'(state_out), 0);
    check("abort_pump", int'(pump), 0);
    check("abort_cup", int'(cup_cnt), 2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart_heat", int'(state_out), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort2_ready", int'(ready), 1);

    // Water fault on HEAT cycle 5.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_state(1);
    repeat (4) @(negedge clk);
    water_ok = 1'b0;
    @(negedge clk);
    water_ok = 1'b1;
    check("fault_err", int'(err), 1);
    check("fault_heater", int'(heater), 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("err_hold", int'(state_out), 6);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("err_abort_ready", int'(ready), 1);
    check("fault_cup", int'(cup_cnt), 2);
    water_ok = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    water_ok = 1'b1;
    check("dry_start_err", int'(state_out), 6);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("dry_abort_ready", int'(ready), 1);

    // Counter wrap after 16 brews from reset.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("wrap_start_cup", int'(cup_cnt), 0);
    for (int i = 1; i <= 16; i++) begin
      brew(1'b0, 1'b0, total, np, nh, npre);
      if (i == 15) check("cup_15", int'(cup_cnt), 15);
    end
    check("cup_wrap", int'(cup_cnt), 0);
    brew(1'b0, 1'b0, total, np, nh, npre);
    check("cup_after_wrap", int'(cup_cnt), 1);

    // Asynchronous reset pulsed between edges during GRIND.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_state(2);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("areset_state", int'(state_out), 0);
    check("areset_ready", int'(ready), 1);
    check("areset_grinder", int'(grinder), 0);
    check("areset_cup", int'(cup_cnt), 0);
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
